fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program sequencer in front of the existing instruction control FSM.
- Fetches 16-bit instructions from a synchronous program memory and loads them into the instruction register.
- Launches each instruction on the control FSM, waits for its completion pulse, then advances or loads the PC.
- Provides halt-at-boundary, resume, a completion watchdog and a retired-instruction counter.

Parameters:
ADDR_W, 8, program-memory address / PC width
DATA_W, 16, instruction width
MEM_LAT, 1, memory read latency in cycles (>=1)
TIMEOUT, 15, max EXEC cycles allowed without exec_done (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin or resume execution (level sampled in IDLE/HALTED)
halt_req  input  1  request stop at next instruction boundary
mem_rd_en  output  1  memory read strobe
mem_addr  output  ADDR_W  memory address (= pc)
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_rd_en
ir  output  DATA_W  instruction register to control FSM
exec_go  output  1  one-cycle launch pulse to control FSM
exec_done  input  1  completion pulse from control FSM
pc_load  input  1  qualify exec_done: take pc_load_val as next PC
pc_load_val  input  ADDR_W  branch target
pc  output  ADDR_W  program counter
busy  output  1  high in FETCH/WAIT/ISSUE/EXEC
halted  output  1  high in HALTED
timeout_err  output  1  sticky watchdog error
retired_cnt  output  16  instructions completed, wraps at 2^16

Behaviour:
- Clock is clk; reset is asynchronous and active-low on reset_n. One clock domain.
- reset_n low: state IDLE; pc=0, ir=0, retired_cnt=0, halt latch=0, timeout_err=0, watchdog=0, latency counter=0.
- Reset asserted mid-operation aborts immediately, including a read in flight. A late mem_rdata is ignored.
- mem_rd_en, exec_go, busy and halted are Moore decodes of state. mem_addr is continuously equal to pc.
- States:
  - IDLE: start=1 -> FETCH.
  - FETCH (1 cycle): mem_rd_en=1; load latency counter=MEM_LAT -> WAIT.
  - WAIT (MEM_LAT cycles): decrement counter. On the edge ending the last WAIT cycle, ir<=mem_rdata -> ISSUE.
  - ISSUE (1 cycle): exec_go=1; clear watchdog -> EXEC.
  - EXEC: sample exec_done every cycle, including the first EXEC cycle.
    - On exec_done=1: pc<=pc_load ? pc_load_val : pc+1 (modulo 2^ADDR_W, FF..F wraps to 0); retired_cnt+=1.
    - Next state is HALTED if the halt latch or halt_req is set, else FETCH.
    - If no exec_done and watchdog reaches TIMEOUT: -> ERROR; pc and retired_cnt unchanged.
  - HALTED: start=1 -> FETCH; clear halt latch. pc is retained, so execution resumes at the next instruction.
  - ERROR: timeout_err=1. Leave only via reset. Ignore start, halt_req and exec_done.
- Latency with start sampled in cycle n:
  - FETCH in cycle n+1.
  - ir valid and exec_go=1 in cycle n+2+MEM_LAT.
  - Minimum per-instruction period with exec_done on the first EXEC cycle: MEM_LAT+3 cycles.
- Halt latch:
  - Set by halt_req=1 in FETCH/WAIT/ISSUE/EXEC; cleared on entry to HALTED or FETCH-from-HALTED.
  - halt_req in IDLE is ignored.
  - halt_req in HALTED holds the block there even if start=1 (halt has priority).
- Simultaneous events and spurious inputs:
  - exec_done and halt_req in the same EXEC cycle: instruction retires and PC updates, then HALTED.
  - exec_done outside EXEC is ignored.
  - pc_load without exec_done has no effect.
- ir changes only on the WAIT->ISSUE edge and is held stable through EXEC.

Test Plan:
- Reset, then start=1 for one cycle, mem[0]=16'h2A05, exec_done returned 2 cycles after exec_go (MEM_LAT=1) -> mem_rd_en in cycle 1, exec_go in cycle 3 with ir=2A05, pc=1, retired_cnt=1, next FETCH addr=1.
- Run 3 instructions, second returns exec_done with pc_load=1, pc_load_val=8'h40 -> fetch addresses 0,1,40h; retired_cnt=3.
- pc preset to FFh via branch, exec_done with pc_load=0 -> pc wraps to 00h, fetch addr 0.
- halt_req pulsed during WAIT of instruction at pc=5 -> instruction completes, pc=6, halted=1, no further mem_rd_en; start=1 -> fetch addr 6, halted=0.
- exec_done withheld after exec_go (TIMEOUT=15) -> ERROR after 15 EXEC cycles, timeout_err=1, busy=0, pc unchanged; start ignored; reset_n low clears all.
- Assert reset_n low asynchronously mid-WAIT (no clock edge) -> all outputs 0 immediately; later mem_rdata does not load ir.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program sequencer: fetches instructions from synchronous memory into ir, launches them on the control FSM, retires on exec_done.
// exec_go follows start by MEM_LAT+2 cycles; each instruction stalls in EXEC until exec_done, bounded by a TIMEOUT watchdog.
module fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              exec_go,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err,
  output logic [15:0]       retired_cnt
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [15:0]       retired_q, retired_d;
  logic              halt_q, halt_d;
  logic              terr_q, terr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    halt_d    = halt_q;
    terr_d    = terr_q;
    wd_d      = wd_q;
    lat_d     = lat_q;

    // Halt requests are only remembered while an instruction is in flight.
    if (halt_req && (state_q inside {S_FETCH, S_WAIT, S_ISSUE, S_EXEC})) begin
      halt_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        lat_d   = LAT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          ir_d    = mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          pc_d      = pc_load ? pc_load_val : pc_q + ADDR_W'(1);
          retired_d = retired_q + 16'd1;
          if (halt_q || halt_req) begin
            halt_d  = 1'b0;
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_HALTED: begin
        // A held halt_req outranks start.
        if (!halt_req && start) begin
          halt_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      halt_q    <= 1'b0;
      terr_q    <= 1'b0;
      wd_q      <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      halt_q    <= halt_d;
      terr_q    <= terr_d;
      wd_q      <= wd_d;
      lat_q     <= lat_d;
    end
  end

  assign mem_rd_en   = (state_q == S_FETCH);
  assign exec_go     = (state_q == S_ISSUE);
  assign busy        = (state_q inside {S_FETCH, S_WAIT, S_ISSUE, S_EXEC});
  assign halted      = (state_q == S_HALTED);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign timeout_err = terr_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: phase-count reference model checked every cycle, plus hand-computed directed expectations.
module tb_fetch_sequencer;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset_n, start, halt_req;
  logic          mem_rd_en, exec_go, exec_done, pc_load;
  logic [AW-1:0] mem_addr, pc_load_val, pc;
  logic [DW-1:0] mem_rdata, ir;
  logic          busy, halted, timeout_err;
  logic [15:0]   retired_cnt;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ir(ir), .exec_go(exec_go), .exec_done(exec_done), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .pc(pc), .busy(busy), .halted(halted),
    .timeout_err(timeout_err), .retired_cnt(retired_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mem    [256];
  bit          br_en  [256];
  logic [7:0]  br_tgt [256];
  int          resp_dly = 2;
  bit          resp_en  = 1'b1;
  logic [7:0]  flog [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synchronous memory (latency 1) and control-FSM responder; branch behaviour is keyed by instruction address.
  initial begin : responder
    int         cd;
    bit         rd_pend;
    logic [7:0] rd_addr;
    cd = 0; rd_pend = 1'b0; rd_addr = '0;
    exec_done = 1'b0; pc_load = 1'b0; pc_load_val = '0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) mem_rdata = mem[rd_addr];
      rd_pend = (mem_rd_en === 1'b1);
      rd_addr = mem_addr;
      exec_done = 1'b0; pc_load = 1'b0; pc_load_val = '0;
      if (exec_go === 1'b1) begin
        cd = resp_dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && resp_en) begin
          exec_done   = 1'b1;
          pc_load     = br_en[pc];
          pc_load_val = br_tgt[pc];
        end
      end
    end
  end

  // Reference model: mode plus cycle offset within the current instruction (0 fetch, LAT+1 launch, beyond that executing).
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;
  int          m_mode = M_IDLE;
  int          m_ph   = 0;
  logic [7:0]  m_pc   = '0;
  logic [15:0] m_ir   = '0;
  logic [15:0] m_ret  = '0;
  bit          m_hl   = 1'b0;
  bit          m_err  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = M_IDLE; m_ph = 0; m_pc = '0; m_ir = '0; m_ret = '0; m_hl = 1'b0; m_err = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_RUN; m_ph = 0; end
        M_RUN: begin
          if (halt_req) m_hl = 1'b1;
          if (m_ph < LAT + 2) begin
            if (m_ph == LAT) m_ir = mem[m_pc];
            m_ph++;
          end else if (exec_done) begin
            m_ret++;
            m_pc = pc_load ? pc_load_val : m_pc + 8'd1;
            if (m_hl) begin m_mode = M_HALT; m_hl = 1'b0; end
            else m_ph = 0;
          end else if (m_ph - (LAT + 2) + 1 >= TMO) begin
            m_mode = M_ERR; m_err = 1'b1;
          end else begin
            m_ph++;
          end
        end
        M_HALT: if (!halt_req && start) begin m_mode = M_RUN; m_ph = 0; m_hl = 1'b0; end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("mem_rd_en",   mem_rd_en,   m_mode == M_RUN && m_ph == 0);
    chk("exec_go",     exec_go,     m_mode == M_RUN && m_ph == LAT + 1);
    chk("busy",        busy,        m_mode == M_RUN);
    chk("halted",      halted,      m_mode == M_HALT);
    chk("timeout_err", timeout_err, m_err);
    chk("pc",          pc,          m_pc);
    chk("mem_addr",    mem_addr,    m_pc);
    chk("ir",          ir,          m_ir);
    chk("retired_cnt", retired_cnt, m_ret);
    if (mem_rd_en === 1'b1) flog.push_back(mem_addr);
  end

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    flog.delete();
    reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_fetch(input logic [7:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (mem_rd_en === 1'b1 && mem_addr === a) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (halted === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_go(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exec_go === 1'b1) begin ok = 1'b1; return; end
    end
  endtask

  initial begin : global_bound
    #200000;
    $display("FAIL global_bound: simulation did not finish in time");
    $fatal(1, "simulation stuck");
  end

  initial begin : main
    bit ok;
    int n;
    reset_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h1000 + 16'(i); br_en[i] = 1'b0; br_tgt[i] = '0;
    end

    // Basic timing, branch to 40h, branch to FFh then wrap to 00h.
    mem[0] = 16'h2A05;
    br_en[1] = 1'b1;    br_tgt[1] = 8'h40;
    br_en[8'h40] = 1'b1; br_tgt[8'h40] = 8'hFF;
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired_cnt, 0);
    start_pulse();
    chk("c1_rd_en", mem_rd_en, 1);
    chk("c1_addr", mem_addr, 0);
    tick(); tick();
    chk("c3_exec_go", exec_go, 1);
    chk("c3_ir", ir, 16'h2A05);
    tick(); tick(); tick();
    chk("c6_pc", pc, 1);
    chk("c6_retired", retired_cnt, 1);
    chk("c6_rd_en", mem_rd_en, 1);
    chk("c6_addr", mem_addr, 1);
    wait_fetch(8'h00, 100, ok);
    chk("wrap_fetch_seen", ok, 1);
    chk("wrap_retired", retired_cnt, 4);
    tick();
    chk("flog_size", flog.size(), 5);
    chk("flog_2", flog[2], 8'h40);
    chk("flog_3", flog[3], 8'hFF);
    chk("flog_4", flog[4], 8'h00);

    // Halt during WAIT at pc=5, halt priority over start, resume at 6, done+halt together.
    resp_dly = 1;
    for (int i = 0; i < 256; i++) br_en[i] = 1'b0;
    br_en[0] = 1'b1; br_tgt[0] = 8'h05;
    do_reset();
    start_pulse();
    wait_fetch(8'h05, 50, ok);
    chk("pc5_fetch_seen", ok, 1);
    tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    wait_halted(50, ok);
    chk("halt_seen", ok, 1);
    chk("halt_pc", pc, 6);
    chk("halt_retired", retired_cnt, 2);
    n = flog.size();
    repeat (6) tick();
    chk("halt_no_fetch", flog.size(), n);
    halt_req = 1'b1; start = 1'b1;
    repeat (2) tick();
    chk("halt_priority", halted, 1);
    halt_req = 1'b0;
    tick();
    start = 1'b0;
    chk("resume_rd_en", mem_rd_en, 1);
    chk("resume_addr", mem_addr, 6);
    chk("resume_halted", halted, 0);
    tick(); tick(); tick();
    halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    chk("done_halt_halted", halted, 1);
    chk("done_halt_pc", pc, 7);
    chk("done_halt_retired", retired_cnt, 3);

    // Watchdog: exec_done withheld.
    resp_en = 1'b0;
    do_reset();
    start_pulse();
    wait_go(50, ok);
    chk("wd_go_seen", ok, 1);
    repeat (TMO) tick();
    chk("wd_last_busy", busy, 1);
    chk("wd_last_err", timeout_err, 0);
    tick();
    chk("wd_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_pc", pc, 0);
    chk("wd_retired", retired_cnt, 0);
    start = 1'b1; halt_req = 1'b1;
    repeat (3) tick();
    chk("err_sticky", timeout_err, 1);
    chk("err_no_fetch", mem_rd_en, 0);
    chk("err_not_halted", halted, 0);
    start = 1'b0; halt_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("err_reset_clears", timeout_err, 0);
    resp_en = 1'b1;

    // Asynchronous reset mid-WAIT; later read data must not reach ir.
    for (int i = 0; i < 256; i++) br_en[i] = 1'b0;
    mem[0] = 16'hBEEF; mem[1] = 16'hCAFE;
    do_reset();
    start_pulse();
    wait_fetch(8'h01, 50, ok);
    chk("ar_fetch_seen", ok, 1);
    chk("ar_ir_before", ir, 16'hBEEF);
    chk("ar_pc_before", pc, 1);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_pc", pc, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_ir", ir, 0);
    chk("ar_busy", busy, 0);
    chk("ar_retired", retired_cnt, 0);
    chk("ar_rd_en", mem_rd_en, 0);
    repeat (3) tick();
    chk("ar_late_rdata", ir, 0);
    reset_n = 1'b1;
    tick();
    chk("ar_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
